// File: rtl/multi_crop_pkg.sv
// rtl/multi_crop_pkg.sv - shared FSM state type and beat geometry for multi_crop_router
//
// Purpose : package imported by multi_crop_router and its sub-modules.
// Contents: PIXELS_PER_BEAT (Mono8 pixels per 256-bit input beat), state_e (frame FSM).
package multi_crop_pkg;

  localparam int PIXELS_PER_BEAT = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/crop_fifo.sv
// rtl/crop_fifo.sv - per-channel registered output FIFO (pixel + last flag)
//
// Purpose : DEPTH-entry FIFO; a pushed word is visible on data_o from the next cycle.
// Ports   : clk, rst_n (async active-low)
//           push_i / push_data_i  - write side; a push while full is dropped
//           pop_i                 - read side; pops when not empty
//           full_o / empty_o      - occupancy flags
//           data_o                - head word, forced to zero while empty
module crop_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] data_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  // Full is judged on the registered count only, so a same-cycle pop never
  // makes room for a push.
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      count_q <= count_q + (AW+1)'(1);
      else if (do_pop && !do_push) count_q <= count_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/multi_crop_router.sv
// rtl/multi_crop_router.sv - splits one Mono8 frame stream into NUM_CROPS cropped pixel streams
//
// Purpose : accepts 32-pixel beats, serialises them one pixel per cycle in raster
//           order and pushes each pixel into every channel whose window contains it.
// Ports   : clk, ap_rst_n (async active-low)
//           ap_start / ap_idle / ap_done     - frame control
//           crop_x0 / crop_y0                - window corners, latched on ap_start
//           s_axis_tvalid/tready/tdata       - 256-bit input beats, pixel 0 in [7:0]
//           m_axis_tvalid/tready/tlast/tdata - per-channel pixel streams
//           crop_err                         - window out of bounds this frame
//           crop_sum                         - per-channel pixel sum (MULTI_CROP_SUM_EN only)
// Macro   : MULTI_CROP_SUM_EN adds crop_sum and its accumulators.
module multi_crop_router
  import multi_crop_pkg::*;
#(
  parameter int IN_ROWS    = 64,
  parameter int IN_COLS    = 64,
  parameter int OUT_ROWS   = 8,
  parameter int OUT_COLS   = 8,
  parameter int NUM_CROPS  = 5,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        ap_rst_n,
  input  logic                        ap_start,
  output logic                        ap_idle,
  output logic                        ap_done,
  input  logic [$clog2(IN_COLS)-1:0]  crop_x0 [NUM_CROPS],
  input  logic [$clog2(IN_ROWS)-1:0]  crop_y0 [NUM_CROPS],
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  input  logic [255:0]                s_axis_tdata,
  output logic [NUM_CROPS-1:0]        m_axis_tvalid,
  input  logic [NUM_CROPS-1:0]        m_axis_tready,
  output logic [NUM_CROPS-1:0]        m_axis_tlast,
  output logic [7:0]                  m_axis_tdata [NUM_CROPS],
  output logic [NUM_CROPS-1:0]        crop_err
`ifdef MULTI_CROP_SUM_EN
  ,
  output logic [$clog2(OUT_ROWS*OUT_COLS*255+1)-1:0] crop_sum [NUM_CROPS]
`endif
);

  localparam int XW = $clog2(IN_COLS);
  localparam int YW = $clog2(IN_ROWS);
  localparam int LW = $clog2(PIXELS_PER_BEAT);

  state_e                             state_q, state_d;
  logic [YW-1:0]                      row_q, row_d;
  logic [XW-1:0]                      col_q, col_d;
  logic [PIXELS_PER_BEAT-1:0][7:0]    beat_q, beat_d;
  logic                               beat_vld_q, beat_vld_d;
  logic [XW-1:0]                      x0_q [NUM_CROPS];
  logic [YW-1:0]                      y0_q [NUM_CROPS];
  logic [NUM_CROPS-1:0]               err_q;

  logic [NUM_CROPS-1:0] in_win, win_last, fifo_full, fifo_empty;
  logic [7:0]           pixel;
  logic                 stall, issue, last_px;

  // IN_COLS is a multiple of the beat width, so the low column bits are the
  // pixel index inside the buffered beat.
  assign pixel   = beat_q[col_q[LW-1:0]];
  assign last_px = (row_q == YW'(IN_ROWS-1)) && (col_q == XW'(IN_COLS-1));

  always_comb begin
    for (int i = 0; i < NUM_CROPS; i++) begin
      in_win[i] = !err_q[i] &&
                  (int'(row_q) >= int'(y0_q[i])) && (int'(row_q) < int'(y0_q[i]) + OUT_ROWS) &&
                  (int'(col_q) >= int'(x0_q[i])) && (int'(col_q) < int'(x0_q[i]) + OUT_COLS);
      win_last[i] = (int'(row_q) == int'(y0_q[i]) + OUT_ROWS - 1) &&
                    (int'(col_q) == int'(x0_q[i]) + OUT_COLS - 1);
    end
  end

  // A pixel waits until every channel that wants it has room.
  assign stall = |(in_win & fifo_full);
  assign issue = (state_q == ST_RUN) && beat_vld_q && !stall;

  assign ap_idle       = (state_q == ST_IDLE);
  assign ap_done       = (state_q == ST_DONE);
  assign s_axis_tready = (state_q == ST_RUN) && !beat_vld_q;
  assign crop_err      = err_q;

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    beat_d     = beat_q;
    beat_vld_d = beat_vld_q;
    case (state_q)
      ST_IDLE: begin
        if (ap_start) begin
          state_d    = ST_RUN;
          row_d      = '0;
          col_d      = '0;
          beat_vld_d = 1'b0;
        end
      end
      ST_RUN: begin
        if (s_axis_tvalid && s_axis_tready) begin
          beat_d     = s_axis_tdata;
          beat_vld_d = 1'b1;
        end
        if (issue) begin
          if (col_q[LW-1:0] == LW'(PIXELS_PER_BEAT-1)) beat_vld_d = 1'b0;
          if (col_q == XW'(IN_COLS-1)) begin
            col_d = '0;
            row_d = row_q + YW'(1);
          end else begin
            col_d = col_q + XW'(1);
          end
          if (last_px) begin
            state_d = ST_DRAIN;
            row_d   = '0;
          end
        end
      end
      ST_DRAIN: if (&fifo_empty) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q    <= ST_IDLE;
      row_q      <= '0;
      col_q      <= '0;
      beat_q     <= '0;
      beat_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      beat_q     <= beat_d;
      beat_vld_q <= beat_vld_d;
    end
  end

  always_ff @(posedge clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      err_q <= '0;
      for (int i = 0; i < NUM_CROPS; i++) begin
        x0_q[i] <= '0;
        y0_q[i] <= '0;
      end
    end else if (ap_idle && ap_start) begin
      for (int i = 0; i < NUM_CROPS; i++) begin
        x0_q[i]  <= crop_x0[i];
        y0_q[i]  <= crop_y0[i];
        err_q[i] <= (int'(crop_x0[i]) + OUT_COLS > IN_COLS) ||
                    (int'(crop_y0[i]) + OUT_ROWS > IN_ROWS);
      end
    end
  end

`ifdef MULTI_CROP_SUM_EN
  localparam int SW = $clog2(OUT_ROWS*OUT_COLS*255+1);
  logic [SW-1:0] sum_q [NUM_CROPS];

  always_ff @(posedge clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      for (int i = 0; i < NUM_CROPS; i++) sum_q[i] <= '0;
    end else if (ap_idle && ap_start) begin
      for (int i = 0; i < NUM_CROPS; i++) sum_q[i] <= '0;
    end else if (issue) begin
      for (int i = 0; i < NUM_CROPS; i++)
        if (in_win[i]) sum_q[i] <= sum_q[i] + SW'(pixel);
    end
  end

  assign crop_sum = sum_q;
`endif

  for (genvar g = 0; g < NUM_CROPS; g++) begin : g_ch
    logic [8:0] head;

    crop_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (9)
    ) u_fifo (
      .clk         (clk),
      .rst_n       (ap_rst_n),
      .push_i      (issue && in_win[g]),
      .push_data_i ({win_last[g], pixel}),
      .pop_i       (m_axis_tready[g]),
      .full_o      (fifo_full[g]),
      .empty_o     (fifo_empty[g]),
      .data_o      (head)
    );

    assign m_axis_tvalid[g] = !fifo_empty[g];
    assign m_axis_tdata[g]  = head[7:0];
    assign m_axis_tlast[g]  = head[8];
  end

endmodule

// File: tb/tb_multi_crop_router.sv
// tb/tb_multi_crop_router.sv - self-checking bench for multi_crop_router (4x64 in, 2x2 crops)
module tb_multi_crop_router;

  localparam int IR = 4, IC = 64, OR = 2, OC = 2, NC = 2, FD = 2;
  localparam int NBEATS = IR * IC / 32;

  logic        clk = 1'b0;
  logic        ap_rst_n, ap_start, ap_idle, ap_done;
  logic [5:0]  crop_x0 [NC];
  logic [1:0]  crop_y0 [NC];
  logic        s_axis_tvalid, s_axis_tready;
  logic [255:0] s_axis_tdata;
  logic [NC-1:0] m_axis_tvalid, m_axis_tready, m_axis_tlast, crop_err;
  logic [7:0]  m_axis_tdata [NC];
`ifdef MULTI_CROP_SUM_EN
  logic [$clog2(OR*OC*255+1)-1:0] crop_sum [NC];
`endif

  always #5 clk = ~clk;

  multi_crop_router #(
    .IN_ROWS(IR), .IN_COLS(IC), .OUT_ROWS(OR), .OUT_COLS(OC),
    .NUM_CROPS(NC), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start), .ap_idle(ap_idle), .ap_done(ap_done),
    .crop_x0(crop_x0), .crop_y0(crop_y0),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .crop_err(crop_err)
`ifdef MULTI_CROP_SUM_EN
    , .crop_sum(crop_sum)
`endif
  );

  int checks = 0, errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Reference model: frame contents and, per channel, the expected pixel list.
  logic [7:0] frame [IR][IC];
  logic [7:0] exp_pix  [NC][OR*OC];
  logic       exp_last [NC][OR*OC];
  int         exp_cnt  [NC];
  int         exp_sum  [NC];
  bit         exp_err  [NC];

  task automatic build_model(input int pmode);
    for (int r = 0; r < IR; r++)
      for (int c = 0; c < IC; c++)
        case (pmode)
          0:       frame[r][c] = 8'(r + c);
          1:       frame[r][c] = 8'($urandom_range(0, 255));
          default: frame[r][c] = 8'hFF;
        endcase
    for (int ch = 0; ch < NC; ch++) begin
      exp_err[ch] = (int'(crop_x0[ch]) + OC > IC) || (int'(crop_y0[ch]) + OR > IR);
      exp_cnt[ch] = 0;
      exp_sum[ch] = 0;
      if (!exp_err[ch])
        for (int r = 0; r < OR; r++)
          for (int c = 0; c < OC; c++) begin
            exp_pix[ch][exp_cnt[ch]]  = frame[int'(crop_y0[ch]) + r][int'(crop_x0[ch]) + c];
            exp_last[ch][exp_cnt[ch]] = (r == OR - 1) && (c == OC - 1);
            exp_sum[ch] += int'(exp_pix[ch][exp_cnt[ch]]);
            exp_cnt[ch]++;
          end
    end
  endtask

  function automatic logic [255:0] beat_data(input int b);
    logic [255:0] d;
    int row, c0;
    row = b / (IC / 32);
    c0  = (b % (IC / 32)) * 32;
    for (int p = 0; p < 32; p++) d[p*8 +: 8] = frame[row][c0 + p];
    return d;
  endfunction

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_s_tready"}, s_axis_tready, 0);
    check_eq({pfx, "_m_tvalid"}, m_axis_tvalid, 0);
    check_eq({pfx, "_m_tlast"}, m_axis_tlast, 0);
    check_eq({pfx, "_m_tdata0"}, m_axis_tdata[0], 0);
    check_eq({pfx, "_m_tdata1"}, m_axis_tdata[1], 0);
    check_eq({pfx, "_done"}, ap_done, 0);
    check_eq({pfx, "_crop_err"}, crop_err, 0);
    check_eq({pfx, "_idle"}, ap_idle, 1);
  endtask

  // rmode: 0 ready high, 1 random ready and source gaps, 2 ch0 held off 100 cycles.
  task automatic run_frame(input int x0a, input int y0a, input int x0b, input int y0b,
                           input int pmode, input int rmode, input int abort_at, input bit align_chk);
    int  rd [NC];
    int  beat, done_cnt;
    bit  hs, finished;
    crop_x0[0] = 6'(x0a); crop_y0[0] = 2'(y0a);
    crop_x0[1] = 6'(x0b); crop_y0[1] = 2'(y0b);
    build_model(pmode);
    for (int ch = 0; ch < NC; ch++) rd[ch] = 0;
    m_axis_tready = (rmode == 2) ? 2'b10 : 2'b11;
    @(posedge clk); #1 ap_start = 1'b1;
    @(posedge clk); #1 ap_start = 1'b0;
    for (int ch = 0; ch < NC; ch++)
      check_eq($sformatf("crop_err%0d", ch), crop_err[ch], exp_err[ch]);
    check_eq("busy_after_start", ap_idle, 0);
    beat = 0; done_cnt = 0; finished = 0;
    s_axis_tdata  = beat_data(0);
    s_axis_tvalid = 1'b1;
    for (int cyc = 0; cyc < 4000 && !finished; cyc++) begin
      @(negedge clk);
      for (int ch = 0; ch < NC; ch++)
        if (m_axis_tvalid[ch] && m_axis_tready[ch]) begin
          if (rd[ch] >= exp_cnt[ch]) check_eq($sformatf("ch%0d_extra", ch), m_axis_tvalid[ch], 0);
          else begin
            check_eq($sformatf("ch%0d_pix%0d", ch, rd[ch]), m_axis_tdata[ch], exp_pix[ch][rd[ch]]);
            check_eq($sformatf("ch%0d_last%0d", ch, rd[ch]), m_axis_tlast[ch], exp_last[ch][rd[ch]]);
            rd[ch]++;
          end
        end
      if (align_chk) begin
        check_eq("align_tvalid", m_axis_tvalid[0], m_axis_tvalid[1]);
        check_eq("align_tdata", m_axis_tdata[0], m_axis_tdata[1]);
      end
      if (rmode == 2 && cyc == 90) begin
        check_eq("stall_s_tready", s_axis_tready, 0);
        check_eq("stall_busy", ap_idle, 0);
      end
      if (ap_done) begin
        done_cnt++;
        for (int ch = 0; ch < NC; ch++) begin
          check_eq($sformatf("ch%0d_count", ch), rd[ch], exp_cnt[ch]);
          check_eq($sformatf("ch%0d_err_hold", ch), crop_err[ch], exp_err[ch]);
`ifdef MULTI_CROP_SUM_EN
          check_eq($sformatf("ch%0d_sum", ch), crop_sum[ch], exp_sum[ch]);
`endif
        end
        finished = 1;
      end
      if (cyc == abort_at) begin
        #2 ap_rst_n = 1'b0;
        #1 check_reset_outputs("midreset");
        s_axis_tvalid = 1'b0;
        @(posedge clk); #1 ap_rst_n = 1'b1;
        return;
      end
      hs = s_axis_tvalid && s_axis_tready;
      @(posedge clk); #1;
      if (hs) beat++;
      s_axis_tdata  = beat_data(beat < NBEATS ? beat : 0);
      s_axis_tvalid = (beat < NBEATS) && (rmode != 1 || $urandom_range(0, 3) != 0);
      case (rmode)
        0:       m_axis_tready = 2'b11;
        1:       m_axis_tready = 2'($urandom_range(0, 3));
        default: m_axis_tready = {1'b1, cyc >= 100};
      endcase
    end
    if (!finished) check_eq("frame_timeout", ap_done, 1);
    else begin
      @(negedge clk);
      check_eq("done_one_cycle", ap_done, 0);
      check_eq("idle_after_done", ap_idle, 1);
      check_eq("done_pulses", done_cnt, 1);
    end
  endtask

  initial begin
    ap_rst_n = 1'b0; ap_start = 1'b0;
    s_axis_tvalid = 1'b0; s_axis_tdata = '0; m_axis_tready = '1;
    crop_x0[0] = '0; crop_x0[1] = '0; crop_y0[0] = '0; crop_y0[1] = '0;
    #12 check_reset_outputs("reset");
    @(posedge clk); #1 ap_rst_n = 1'b1;

    // Corner crops, pixel = row + col: ch0 0,1,1,2 ; ch1 64,65,65,66.
    run_frame(0, 0, 62, 2, 0, 0, -1, 0);
    // Out-of-bounds window on ch0.
    run_frame(63, 0, 10, 1, 1, 0, -1, 0);
    // Back-pressure on ch0 with a 2-deep FIFO.
    run_frame(0, 0, 30, 1, 1, 2, -1, 0);
    // Identical windows stay cycle-aligned.
    run_frame(4, 1, 4, 1, 1, 0, -1, 1);
    // Reset mid-frame, then a clean frame.
    run_frame(0, 0, 40, 2, 1, 0, 40, 0);
    run_frame(7, 1, 33, 2, 1, 0, -1, 0);
    // Saturated frame (sum 1020 per channel when accumulators are built).
    run_frame(0, 0, 5, 2, 2, 0, -1, 0);
    // Random windows, ready and source gaps.
    for (int k = 0; k < 6; k++)
      run_frame($urandom_range(0, 63), $urandom_range(0, 3),
                $urandom_range(0, 63), $urandom_range(0, 3), 1, 1, -1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
